// File: rtl/fsmc_master_bridge.sv
// fsmc_master_bridge: FSMC bus initiator turning single-word requests into multiplexed AD/NADV/NWE/NOE cycles.
// Define FSMC_MASTER_QUEUE_EN to add a 2-entry in-order request FIFO ahead of the bus FSM.
module fsmc_master_bridge #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16,
    parameter int ADDSET     = 2,
    parameter int ADDHLD     = 1,
    parameter int DATAST     = 6,
    parameter int DATAHLD    = 1,
    parameter int BUSTURN    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    inout  wire  [ADDR_WIDTH-1:0] AD,
    output logic                  NADV,
    output logic                  NWE,
    output logic                  NOE
);
    localparam int M1   = ADDSET > ADDHLD ? ADDSET : ADDHLD;
    localparam int M2   = M1 > DATAST ? M1 : DATAST;
    localparam int M3   = M2 > DATAHLD ? M2 : DATAHLD;
    localparam int MAXP = M3 > BUSTURN ? M3 : BUSTURN;
    localparam int CW   = $clog2(MAXP + 1);

    typedef enum logic [2:0] {IDLE, ASET, AHLD, WDAT, RDAT, DHLD, TURN} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  last, start, we_q, ad_oe, src_we;
    logic [DATA_WIDTH-1:0] wdata_q, src_wdata;
    logic [ADDR_WIDTH-1:0] ad_q, src_addr;

`ifdef FSMC_MASTER_QUEUE_EN
    logic [ADDR_WIDTH+DATA_WIDTH:0] fifo [2];
    logic                           rd_ptr, wr_ptr, push, pop, bypass;
    logic [1:0]                     fcnt;

    // An empty FIFO is bypassed so bus timing from accept is identical to the unqueued build
    assign req_ready = fcnt != 2'd2;
    assign bypass    = state == IDLE && fcnt == 2'd0;
    assign pop       = state == IDLE && fcnt != 2'd0;
    assign push      = req && req_ready && !bypass;
    assign start     = state == IDLE && (fcnt != 2'd0 || req);
    assign {src_we, src_addr, src_wdata} = fcnt != 2'd0 ? fifo[rd_ptr] : {req_we, req_addr, req_wdata};

    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= {req_we, req_addr, req_wdata};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            fcnt   <= 2'd0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop) rd_ptr <= !rd_ptr;
            fcnt <= fcnt + 2'(push) - 2'(pop);
        end
`else
    assign req_ready = state == IDLE;
    assign start     = req && state == IDLE;
    assign src_we    = req_we;
    assign src_addr  = req_addr;
    assign src_wdata = req_wdata;
`endif

    assign last = cnt == '0;
    assign busy = state != IDLE;
    assign AD   = ad_oe ? ad_q : 'z;

    always_comb begin
        state_nx = state;
        cnt_nx   = last ? cnt : cnt - CW'(1);
        unique case (state)
            IDLE: if (start) begin
                state_nx = ASET;
                cnt_nx   = CW'(ADDSET - 1);
            end
            ASET: if (last) begin
                state_nx = AHLD;
                cnt_nx   = CW'(ADDHLD - 1);
            end
            AHLD: if (last) begin
                state_nx = we_q ? WDAT : RDAT;
                cnt_nx   = CW'(DATAST - 1);
            end
            WDAT, RDAT: if (last) begin
                state_nx = DHLD;
                cnt_nx   = CW'(DATAHLD - 1);
            end
            DHLD: if (last) begin
                state_nx = BUSTURN == 0 ? IDLE : TURN;
                cnt_nx   = CW'(BUSTURN - 1);
            end
            TURN: if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes and AD drive are registered from the next state so they change cleanly on the edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            ad_q      <= '0;
            ad_oe     <= 1'b0;
            NADV      <= 1'b1;
            NWE       <= 1'b1;
            NOE       <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (start) begin
                we_q    <= src_we;
                wdata_q <= src_wdata;
                ad_q    <= src_addr;
            end else if (state == AHLD && state_nx == WDAT) begin
                ad_q <= ADDR_WIDTH'(wdata_q);
            end
            ad_oe     <= state_nx inside {ASET, AHLD, WDAT} || (state_nx == DHLD && we_q);
            NADV      <= state_nx != ASET;
            NWE       <= state_nx != WDAT;
            NOE       <= state_nx != RDAT;
            rsp_valid <= state == DHLD && last;
            if (state == RDAT && last) rsp_rdata <= AD[DATA_WIDTH-1:0];
        end
endmodule
